// File: rtl/popcount_expander_4to13_pkg.sv
// Shared NPU popcount constants and types, common to the 13-to-4 compression
// adders and to the unary expander that undoes them.
package npu_pc_pkg;

   // Frame length in beats and largest legal population count.
   localparam int N_BITS = 13;
   // Count width; 2**CW must exceed N_BITS so N_BITS itself is representable.
   localparam int CW = 4;

   // Expander control state.
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage : npu_pc_pkg

// File: rtl/popcount_expander_4to13_if.sv
// Count-in / unary-beat-out handshake bundle of the popcount expander.
// The slave modport is the expander; the master modport is its environment
// (count producer plus beat consumer).
interface popcount_expander_4to13_if #(
   parameter int W = npu_pc_pkg::CW
);
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_count;
   logic         m_valid;
   logic         m_ready;
   logic         m_bit;
   logic         m_first;
   logic         m_last;

   modport slave (
      input  s_valid,
      input  s_count,
      input  m_ready,
      output s_ready,
      output m_valid,
      output m_bit,
      output m_first,
      output m_last
   );

   modport master (
      output s_valid,
      output s_count,
      output m_ready,
      input  s_ready,
      input  m_valid,
      input  m_bit,
      input  m_first,
      input  m_last
   );
endinterface : popcount_expander_4to13_if

// File: rtl/popcount_expander_4to13.sv
// Popcount expander: turns a count (0..N_BITS) into an N_BITS-beat unary
// bit-serial frame holding exactly that many ones. Out-of-range counts are
// clamped to N_BITS and flagged on the sticky sat_err. A count offered on the
// last beat of a frame is taken in the same cycle so frames run gap-free.
module popcount_expander_4to13 #(
   parameter int N_BITS = npu_pc_pkg::N_BITS,
   parameter int CW     = npu_pc_pkg::CW,
   // 0: ones first (beat i is 1 iff i < count); 1: ones last.
   parameter int ORDER  = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   output logic                         sat_err,
   popcount_expander_4to13_if.slave     bus
);
   import npu_pc_pkg::*;

   localparam logic [CW-1:0] MAX_CNT  = CW'(N_BITS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_BITS - 1);

   state_t        state_reg;
   logic [CW-1:0] idx_reg;
   logic [CW-1:0] cnt_reg;
   logic          sat_err_reg;

   logic          in_send;
   logic          at_last;
   logic          beat_acc;
   logic          cnt_acc;
   logic          over_range;
   logic [CW-1:0] cnt_clamped;
   logic          unary_bit;

   assign in_send  = (state_reg == SEND);
   assign at_last  = in_send && (idx_reg == LAST_IDX);
   assign beat_acc = in_send && bus.m_ready;

   // The only input-to-output combinational path: m_ready -> s_ready, which
   // lets the next count load on the closing beat without a bubble.
   assign bus.s_ready = !in_send || (at_last && bus.m_ready);
   assign cnt_acc     = bus.s_valid && bus.s_ready;

   assign over_range  = (bus.s_count > MAX_CNT);
   assign cnt_clamped = over_range ? MAX_CNT : bus.s_count;

   // Thermometer decode of the held count against the beat index.
   generate
      if (ORDER == 0) begin : g_ones_first
         assign unary_bit = (idx_reg < cnt_reg);
      end else begin : g_ones_last
         assign unary_bit = (idx_reg >= (MAX_CNT - cnt_reg));
      end
   endgenerate

   // Outputs are decoded from registers only and forced low outside a frame,
   // so they stay put for as long as the consumer stalls.
   assign bus.m_valid = in_send;
   assign bus.m_bit   = in_send && unary_bit;
   assign bus.m_first = in_send && (idx_reg == '0);
   assign bus.m_last  = at_last;
   assign sat_err     = sat_err_reg;

   // Frame control: load a clamped count, step through the beats, chain or idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cnt_acc) begin
                  cnt_reg   <= cnt_clamped;
                  idx_reg   <= '0;
                  state_reg <= SEND;
               end
            end
            SEND: begin
               if (beat_acc) begin
                  if (!at_last) begin
                     idx_reg <= idx_reg + 1'b1;
                  end else if (cnt_acc) begin
                     cnt_reg <= cnt_clamped;
                     idx_reg <= '0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Sticky saturation flag; a saturating accept beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_err_reg <= 1'b0;
      end else if (cnt_acc && over_range) begin
         sat_err_reg <= 1'b1;
      end else if (clr) begin
         sat_err_reg <= 1'b0;
      end
   end

endmodule : popcount_expander_4to13

// File: tb/tb_popcount_expander_4to13.sv
// Bench for the popcount expander: an ORDER=0 and an ORDER=1 instance share
// one stimulus stream and are checked every cycle against a queue of the
// beats each accepted count must produce, plus literal frame expectations.
module tb_popcount_expander_4to13;
   import npu_pc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       s_valid = 1'b0;
   logic [3:0] s_count = 4'd0;
   logic       m_ready = 1'b0;
   logic       clr     = 1'b0;
   logic       sat0, sat1;

   popcount_expander_4to13_if #(.W(4)) if0 ();
   popcount_expander_4to13_if #(.W(4)) if1 ();

   assign if0.s_valid = s_valid;
   assign if0.s_count = s_count;
   assign if0.m_ready = m_ready;
   assign if1.s_valid = s_valid;
   assign if1.s_count = s_count;
   assign if1.m_ready = m_ready;

   popcount_expander_4to13 #(.N_BITS(13), .CW(4), .ORDER(0)) u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .sat_err (sat0),
      .bus     (if0.slave)
   );

   popcount_expander_4to13 #(.N_BITS(13), .CW(4), .ORDER(1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .sat_err (sat1),
      .bus     (if1.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each accepted count appends its whole frame of expected beats; each
   // accepted beat removes one. Outputs are valid iff the queue is non-empty.
   typedef struct packed {
      logic b0;   // bit for ones-first
      logic b1;   // bit for ones-last
      logic f;
      logic l;
   } beat_t;

   beat_t q[$];
   logic  sat_exp = 1'b0;
   bit    mdl_sready, mdl_take;
   int    mdl_cc;
   beat_t mdl_b;

   // Model update on each clock edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         sat_exp = 1'b0;
      end else begin
         mdl_sready = (q.size() == 0) || (q.size() == 1 && m_ready);
         mdl_take   = s_valid && mdl_sready;
         if (q.size() > 0 && m_ready) void'(q.pop_front());
         if (mdl_take) begin
            mdl_cc = (int'(s_count) > 13) ? 13 : int'(s_count);
            for (int i = 0; i < 13; i++) begin
               mdl_b.b0 = (i < mdl_cc);
               mdl_b.b1 = (i >= 13 - mdl_cc);
               mdl_b.f  = (i == 0);
               mdl_b.l  = (i == 12);
               q.push_back(mdl_b);
            end
         end
         if (mdl_take && s_count > 4'd13) sat_exp = 1'b1;
         else if (clr)                    sat_exp = 1'b0;
      end
   end

   // ---------------- compare + frame recorder ----------------
   logic [12:0] acc0, acc1;
   logic [12:0] frames0[$];
   logic [12:0] frames1[$];
   int          pos = 0;
   int          cyc = 0;
   int          first_v = -1;
   int          last_v  = -1;
   bit          prev_stall = 0;
   logic [2:0]  prev_out0, prev_out1;
   bit          exp_v;

   // Compare both instances with the model once per cycle, away from the edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pos        = 0;
         prev_stall = 0;
         chk("rst_m_valid0", 32'(if0.m_valid), 32'd0);
         chk("rst_m_valid1", 32'(if1.m_valid), 32'd0);
         chk("rst_s_ready0", 32'(if0.s_ready), 32'd1);
         chk("rst_sat0",     32'(sat0),        32'd0);
         chk("rst_sat1",     32'(sat1),        32'd0);
      end else begin
         exp_v = (q.size() > 0);
         chk("m_valid0", 32'(if0.m_valid), 32'(exp_v));
         chk("m_valid1", 32'(if1.m_valid), 32'(exp_v));
         if (exp_v) begin
            chk("m_bit0",   32'(if0.m_bit),   32'(q[0].b0));
            chk("m_bit1",   32'(if1.m_bit),   32'(q[0].b1));
            chk("m_first0", 32'(if0.m_first), 32'(q[0].f));
            chk("m_first1", 32'(if1.m_first), 32'(q[0].f));
            chk("m_last0",  32'(if0.m_last),  32'(q[0].l));
            chk("m_last1",  32'(if1.m_last),  32'(q[0].l));
         end else begin
            chk("idle_out0", 32'({if0.m_bit, if0.m_first, if0.m_last}), 32'd0);
            chk("idle_out1", 32'({if1.m_bit, if1.m_first, if1.m_last}), 32'd0);
         end
         chk("s_ready0", 32'(if0.s_ready),
             32'((q.size() == 0) || (q.size() == 1 && m_ready)));
         chk("s_ready1", 32'(if1.s_ready),
             32'((q.size() == 0) || (q.size() == 1 && m_ready)));
         chk("sat_err0", 32'(sat0), 32'(sat_exp));
         chk("sat_err1", 32'(sat1), 32'(sat_exp));
         if (prev_stall) begin
            chk("stall_hold0", 32'({if0.m_bit, if0.m_first, if0.m_last}), 32'(prev_out0));
            chk("stall_hold1", 32'({if1.m_bit, if1.m_first, if1.m_last}), 32'(prev_out1));
         end
         prev_stall = if0.m_valid && !m_ready;
         prev_out0  = {if0.m_bit, if0.m_first, if0.m_last};
         prev_out1  = {if1.m_bit, if1.m_first, if1.m_last};
         if (if0.m_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (if0.m_valid && m_ready && pos < 13) begin
            acc0[pos] = if0.m_bit;
            acc1[pos] = if1.m_bit;
            if (pos == 12) begin
               frames0.push_back(acc0);
               frames1.push_back(acc1);
               $display("frame %0d: ones-first %013b ones-last %013b",
                        frames0.size(), acc0, acc1);
               pos = 0;
            end else begin
               pos++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   bit rand_mr = 0;

   function automatic logic [12:0] last0();
      return (frames0.size() > 0) ? frames0[frames0.size()-1] : 13'bx;
   endfunction
   function automatic logic [12:0] last1();
      return (frames1.size() > 0) ? frames1[frames1.size()-1] : 13'bx;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
      if (rand_mr) m_ready = 1'($urandom_range(0, 1));
   endtask

   // Offer a count until it is taken; optionally drop s_valid afterwards.
   task automatic accept_count(input logic [3:0] c, input bit drop);
      bit acc;
      bit done;
      done    = 0;
      s_valid = 1'b1;
      s_count = c;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         acc = if0.s_ready;
         step();
         if (acc) done = 1;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      if (drop) begin
         s_valid = 1'b0;
         s_count = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic wait_frames(input int target);
      for (int k = 0; k < 3000 && frames0.size() < target; k++) step();
      if (frames0.size() < target) chk("frame_timeout", 32'(frames0.size()), 32'(target));
   endtask

   // ---------------- test sequence ----------------
   int base;

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #2;
      @(negedge clk);
      chk("reset_s_ready", 32'(if0.s_ready), 32'd1);
      chk("reset_m_valid", 32'(if0.m_valid), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      m_ready = 1'b1;
      step();

      // Single frame, count 5.
      base = frames0.size();
      accept_count(4'd5, 1);
      wait_frames(base + 1);
      chk("single_f0", 32'(last0()), 32'h001F);
      chk("single_f1", 32'(last1()), 32'h1F00);
      @(negedge clk);
      chk("single_idle", 32'(if0.s_ready), 32'd1);
      step();

      // Back-to-back 13, 0, 7 with s_valid held.
      first_v = -1;
      last_v  = -1;
      base = frames0.size();
      accept_count(4'd13, 0);
      accept_count(4'd0, 0);
      accept_count(4'd7, 1);
      wait_frames(base + 3);
      step();
      chk("b2b_f13", 32'(frames0[base]),     32'h1FFF);
      chk("b2b_f0",  32'(frames0[base + 1]), 32'h0000);
      chk("b2b_f7",  32'(frames0[base + 2]), 32'h007F);
      chk("b2b_span", 32'(last_v - first_v + 1), 32'd39);

      // Backpressure, count 9.
      base = frames0.size();
      rand_mr = 1;
      accept_count(4'd9, 1);
      wait_frames(base + 1);
      rand_mr = 0;
      m_ready = 1'b1;
      chk("bp_f0", 32'(last0()), 32'h01FF);
      chk("bp_f1", 32'(last1()), 32'h1FF0);

      // Randomised counts, gaps, backpressure and clears.
      base = frames0.size();
      rand_mr = 1;
      for (int n = 0; n < 25; n++) begin
         clr = 1'($urandom_range(0, 3) == 0);
         accept_count(4'($urandom_range(0, 15)), 1);
         clr = 1'b0;
         repeat ($urandom_range(0, 15)) step();
      end
      wait_frames(base + 25);
      rand_mr = 0;
      m_ready = 1'b1;
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();

      // Saturation: 15 clamps to 13, clear, then clear + 14 in one cycle.
      base = frames0.size();
      accept_count(4'd15, 1);
      @(negedge clk);
      chk("sat_set", 32'(sat0), 32'd1);
      wait_frames(base + 1);
      chk("sat_frame", 32'(last0()), 32'h1FFF);
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      @(negedge clk);
      chk("sat_clr", 32'(sat0), 32'd0);
      step();
      clr = 1'b1;
      accept_count(4'd14, 1);
      clr = 1'b0;
      @(negedge clk);
      chk("sat_set_wins", 32'(sat0), 32'd1);
      wait_frames(base + 2);
      step();

      // Count 3 on both orders.
      base = frames0.size();
      accept_count(4'd3, 1);
      wait_frames(base + 1);
      chk("order0_c3", 32'(last0()), 32'h0007);
      chk("order1_c3", 32'(last1()), 32'h1C00);
      step();

      // Reset after beat 6 of a count-10 frame.
      accept_count(4'd10, 1);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_m_valid0", 32'(if0.m_valid), 32'd0);
      chk("midrst_m_valid1", 32'(if1.m_valid), 32'd0);
      chk("midrst_sat", 32'(sat0), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_s_ready", 32'(if0.s_ready), 32'd1);
      step();
      base = frames0.size();
      accept_count(4'd2, 1);
      wait_frames(base + 1);
      chk("postrst_frame", 32'(last0()), 32'h0003);
      repeat (3) step();
      chk("postrst_count", 32'(frames0.size()), 32'(base + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_popcount_expander_4to13
